bin_to_bcd_seq: RTL and testbench

Sequential double-dabble converter that turns a 32-bit binary value into packed BCD digits. It sits directly upstream of the decimal seven-segment driver: the CPU display register value enters here, and the digit vector plus an overflow flag feed the display multiplexer. One shift per clock replaces the combinational divide/modulo chain and removes that chain from the critical path.

---
 rtl/display_pkg.sv | 30 +++
 rtl/bin_to_bcd_seq_add3_digit.sv | 27 ++
 rtl/bin_to_bcd_seq.sv | 171 +++++++++++++++++
 tb/tb_bin_to_bcd_seq.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// -----------------------------------------------------------------------------
// display_pkg
//
// Constants and types shared by the decimal display path: the binary-to-BCD
// converter and the seven-segment multiplexer/driver stages that follow it.
//
// Contents:
//   state_t         converter control states {IDLE, SHIFT, DONE}
//   BCD_DIGIT_W     bits per packed BCD digit
//   BCD_NINE        BCD nine, used to build the saturated "all nines" value
//   ADD3_THRESHOLD  double-dabble correction threshold
//   ANODE_W         digit-select (anode) width of the display
//   CATHODE_W       segment (cathode) width: seven segments plus decimal point
// -----------------------------------------------------------------------------
package display_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int unsigned BCD_DIGIT_W    = 4;
    localparam logic [3:0]  BCD_NINE       = 4'h9;
    localparam logic [3:0]  ADD3_THRESHOLD = 4'd5;

    localparam int unsigned ANODE_W   = 8;
    localparam int unsigned CATHODE_W = 8;

endpackage : display_pkg

// File: rtl/bin_to_bcd_seq_add3_digit.sv
// -----------------------------------------------------------------------------
// bcd_add3_digit
//
// Double-dabble per-digit correction. A digit of 5 or more is bumped by 3 so
// that the following left shift carries correctly into the next decimal
// digit. The sum stays within 4 bits; there is no carry into the neighbour
// digit (legal BCD digits 5..9 map to 8..12).
//
// Ports:
//   digit_in   input  [3:0]  BCD digit before the shift
//   digit_out  output [3:0]  corrected digit
// -----------------------------------------------------------------------------
module bcd_add3_digit
    import display_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_in,
    output logic [BCD_DIGIT_W-1:0] digit_out
);

    always_comb begin
        digit_out = digit_in;
        if (digit_in >= ADD3_THRESHOLD) begin
            digit_out = digit_in + 4'd3;
        end
    end

endmodule : bcd_add3_digit

// File: rtl/bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// bin_to_bcd_seq
//
// Sequential double-dabble converter: one shift per clock turns an IN_WIDTH
// binary value into packed BCD for the decimal seven-segment display. The
// whole conversion takes IN_WIDTH+2 cycles (accept, IN_WIDTH shifts, done).
//
// Parameters:
//   IN_WIDTH    width of the binary input (>= 4)
//   BCD_DIGITS  internal digit count, must cover 2^IN_WIDTH-1
//   OUT_DIGITS  digits presented on bcd_out (<= BCD_DIGITS)
//
// Ports:
//   clk        input   system clock
//   resetn     input   asynchronous active-low reset
//   in_valid   input   conversion request, bin_in valid
//   in_ready   output  converter idle, request will be accepted
//   bin_in     input   binary value to convert
//   out_valid  output  one-cycle pulse, bcd_out/overflow just updated
//   bcd_out    output  packed BCD, digit 0 in [3:0]; held until next result
//   overflow   output  value exceeds 10^OUT_DIGITS-1
//
// Build option:
//   BCD_SATURATE_EN  when defined, an overflowing result shows all nines on
//                    bcd_out; otherwise bcd_out carries the true low digits.
//
// States:
//   state | meaning
//   IDLE  | waiting for in_valid; in_ready high
//   SHIFT | one correct-and-shift step per clock, IN_WIDTH steps
//   DONE  | publish digits and overflow, pulse out_valid
// -----------------------------------------------------------------------------
module bin_to_bcd_seq
    import display_pkg::*;
#(
    parameter int unsigned IN_WIDTH   = 32,
    parameter int unsigned BCD_DIGITS = 10,
    parameter int unsigned OUT_DIGITS = 8
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [IN_WIDTH-1:0]               bin_in,
    output logic                              out_valid,
    output logic [BCD_DIGIT_W*OUT_DIGITS-1:0] bcd_out,
    output logic                              overflow
);

    localparam int unsigned ACC_W = BCD_DIGIT_W * BCD_DIGITS;
    localparam int unsigned OUT_W = BCD_DIGIT_W * OUT_DIGITS;
    localparam int unsigned SR_W  = ACC_W + IN_WIDTH;
    localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);

    // Counter value seen during the final shift; the transition to DONE is
    // taken on that edge so exactly IN_WIDTH shifts happen.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(IN_WIDTH - 1);

    state_t state_q;
    state_t state_d;

    logic [IN_WIDTH-1:0] bin_sr;
    logic [ACC_W-1:0]    acc;
    logic [ACC_W-1:0]    acc_corr;
    logic [SR_W-1:0]     shifted;
    logic [CNT_W-1:0]    cnt;
    logic                last_shift;
    logic                acc_hi_nz;
    logic [OUT_W-1:0]    bcd_next;

    // ------------------------------------------------------------------
    // Per-digit +3 correction, applied to every digit before each shift
    // ------------------------------------------------------------------
    for (genvar g = 0; g < BCD_DIGITS; g++) begin : g_add3
        bcd_add3_digit u_add3 (
            .digit_in  (acc[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_out (acc_corr[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The binary register's MSB moves into the accumulator's LSB.
    assign shifted    = {acc_corr, bin_sr} << 1;
    assign last_shift = (cnt == LAST_CNT);

    // Digits above the displayed ones; any non-zero digit means the value
    // does not fit on the display.
    if (OUT_DIGITS < BCD_DIGITS) begin : g_hi
        assign acc_hi_nz = |acc[ACC_W-1:OUT_W];
    end else begin : g_no_hi
        assign acc_hi_nz = 1'b0;
    end

`ifdef BCD_SATURATE_EN
    assign bcd_next = acc_hi_nz ? {OUT_DIGITS{BCD_NINE}} : acc[OUT_W-1:0];
`else
    assign bcd_next = acc[OUT_W-1:0];
`endif

    assign in_ready = (state_q == IDLE);

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (last_shift) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: shift register, counter and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bin_sr    <= '0;
            acc       <= '0;
            cnt       <= '0;
            bcd_out   <= '0;
            overflow  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        bin_sr <= bin_in;
                        acc    <= '0;
                        cnt    <= '0;
                    end
                end
                SHIFT: begin
                    acc    <= shifted[SR_W-1:IN_WIDTH];
                    bin_sr <= shifted[IN_WIDTH-1:0];
                    cnt    <= cnt + CNT_W'(1);
                end
                DONE: begin
                    bcd_out   <= bcd_next;
                    overflow  <= acc_hi_nz;
                    out_valid <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : bin_to_bcd_seq

// File: tb/tb_bin_to_bcd_seq.sv
// -----------------------------------------------------------------------------
// tb_bin_to_bcd_seq
//
// Directed bench for bin_to_bcd_seq. A cycle-level reference model computes
// the decimal digits with plain arithmetic and tracks when each result is due;
// a compare process checks in_ready, out_valid, bcd_out and overflow against
// it on every falling edge. Directed sequences also pin absolute values and
// the accept-to-result latency.
// -----------------------------------------------------------------------------
module tb_bin_to_bcd_seq;

    localparam int unsigned IN_WIDTH   = 32;
    localparam int unsigned BCD_DIGITS = 10;
    localparam int unsigned OUT_DIGITS = 8;
    localparam int unsigned LATENCY    = IN_WIDTH + 1;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] bin_in;
    logic        out_valid;
    logic [31:0] bcd_out;
    logic        overflow;

    int n_checks = 0;
    int n_fail   = 0;
    bit cmp_en   = 1'b0;

    bin_to_bcd_seq #(
        .IN_WIDTH   (IN_WIDTH),
        .BCD_DIGITS (BCD_DIGITS),
        .OUT_DIGITS (OUT_DIGITS)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .bin_in    (bin_in),
        .out_valid (out_valid),
        .bcd_out   (bcd_out),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    function automatic logic [31:0] model_digits(input longint unsigned v);
        logic [31:0] r;
        longint unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < OUT_DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic model_ovf(input longint unsigned v);
        return v > 64'd99999999;
    endfunction

    function automatic logic [31:0] model_bcd(input longint unsigned v);
`ifdef BCD_SATURATE_EN
        if (model_ovf(v)) return 32'h99999999;
`endif
        return model_digits(v);
    endfunction

    int          m_cd    = 0;
    logic [31:0] m_val   = '0;
    logic        m_valid = 1'b0;
    logic [31:0] m_bcd   = '0;
    logic        m_ovf   = 1'b0;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m_cd    <= 0;
            m_val   <= '0;
            m_valid <= 1'b0;
            m_bcd   <= '0;
            m_ovf   <= 1'b0;
        end else begin
            m_valid <= 1'b0;
            if (m_cd == 0) begin
                if (in_valid) begin
                    m_val <= bin_in;
                    m_cd  <= LATENCY;
                end
            end else begin
                m_cd <= m_cd - 1;
                if (m_cd == 1) begin
                    m_valid <= 1'b1;
                    m_bcd   <= model_bcd(longint'(m_val));
                    m_ovf   <= model_ovf(longint'(m_val));
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            check("in_ready",  64'(in_ready),  64'(m_cd == 0));
            check("out_valid", 64'(out_valid), 64'(m_valid));
            check("bcd_out",   64'(bcd_out),   64'(m_bcd));
            check("overflow",  64'(overflow),  64'(m_ovf));
        end
    end

    // ------------------------------------------------------------------
    // Directed stimulus
    // ------------------------------------------------------------------
    task automatic conv(input logic [31:0] v, input logic [31:0] exp_bcd, input logic exp_ovf);
        int n;
        bit got;
        @(negedge clk);
        check("ready_before_accept", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        bin_in   = v;
        @(posedge clk);
        n   = 0;
        got = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        bin_in   = $urandom;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk);
            n++;
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("result_seen", 64'(got), 64'd1);
        check("latency",     64'(n),   64'(LATENCY));
        check("lit_bcd",     64'(bcd_out),  64'(exp_bcd));
        check("lit_ovf",     64'(overflow), 64'(exp_ovf));
        @(negedge clk);
        check("pulse_width", 64'(out_valid), 64'd0);
        check("bcd_hold",    64'(bcd_out),   64'(exp_bcd));
    endtask

    initial begin
        int  pulses;
        bit  got;
        logic [31:0] exp_big;
        logic [31:0] exp_max;

        resetn   = 1'b0;
        in_valid = 1'b0;
        bin_in   = '0;
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        cmp_en = 1'b1;
        repeat (3) @(negedge clk);

        // reset asserted while idle, then released
        resetn = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_bcd_out",   64'(bcd_out),   64'd0);
        check("rst_overflow",  64'(overflow),  64'd0);

        // model pins
        check("model_12345678", 64'(model_digits(64'd12345678)), 64'h12345678);
        check("model_ffffffff", 64'(model_digits(64'd4294967295)), 64'h94967295);
        check("model_ovf_1e8",  64'(model_ovf(64'd100000000)), 64'd1);

`ifdef BCD_SATURATE_EN
        exp_big = 32'h99999999;
        exp_max = 32'h99999999;
`else
        exp_big = 32'h00000000;
        exp_max = 32'h94967295;
`endif
        conv(32'd0,          32'h00000000, 1'b0);
        conv(32'd12345678,   32'h12345678, 1'b0);
        conv(32'd99999999,   32'h99999999, 1'b0);
        conv(32'd100000000,  exp_big,      1'b1);
        conv(32'hFFFFFFFF,   exp_max,      1'b1);
        conv(32'd9,          32'h00000009, 1'b0);

        // busy requester: accept 42, then hold in_valid with 7 throughout
        @(negedge clk);
        in_valid = 1'b1;
        bin_in   = 32'd42;
        @(posedge clk);
        @(negedge clk);
        bin_in = 32'd7;
        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            if (out_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("busy_result_seen", 64'(got),      64'd1);
        check("busy_result_42",   64'(bcd_out),  64'h00000042);
        check("busy_ready_high",  64'(in_ready), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("second_accepted",  64'(in_ready), 64'd0);
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        @(posedge clk);
        #1 resetn = 1'b0;
        @(negedge clk);
        check("abort_in_ready",  64'(in_ready),  64'd1);
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_bcd_out",   64'(bcd_out),   64'd0);
        check("abort_overflow",  64'(overflow),  64'd0);
        resetn = 1'b1;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort_no_pulse", 64'(pulses), 64'd0);

        conv(32'd305419896, 32'h05419896, 1'b1 ^ 1'b0);

        repeat (2) @(negedge clk);
        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_bin_to_bcd_seq
